// File: rtl/rca_seq_adder.sv
// rca_seq_adder: multi-cycle add/subtract unit. One CHUNK-bit ripple stage is
// reused for NCHUNK = WIDTH/CHUNK clocks, and the carry between chunks is held
// in a register. Both sides use a valid/ready handshake.
//
// Ports:
//   clk, rst              clock; synchronous active-high reset
//   in_valid / in_ready   operand handshake (in_ready is high only in IDLE)
//   a, b                  WIDTH-bit operands
//   carry_in              carry in for add, borrow in for subtract
//   sub                   0 = a + b + carry_in, 1 = a - b - carry_in
//   out_valid / out_ready result handshake
//   sum                   WIDTH-bit result, modulo 2^WIDTH
//   carry_out             final carry; for subtract, 1 means no borrow
//   overflow              signed overflow of the operation
//   zero                  sum == 0
//
// WIDTH must be a positive multiple of CHUNK.
module rca_seq_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CNT_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NCHUNK - 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             c_q, c_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_out_q, carry_out_d;
  logic             overflow_q, overflow_d;
  logic             zero_q, zero_d;

  logic [CHUNK:0]   chunk_res;
  logic [WIDTH-1:0] result;

  // Operands are shifted down by one chunk per clock, so the ripple stage
  // always works on the low CHUNK bits. The partial result is shifted in from
  // the top, so after NCHUNK steps chunk 0 sits at bit 0. On the last step the
  // low chunk of a_q/b_q holds the original sign bits, which the overflow
  // check needs.
  always_comb begin
    chunk_res = {1'b0, a_q[CHUNK-1:0]} + {1'b0, b_q[CHUNK-1:0]} + {{CHUNK{1'b0}}, c_q};
    result    = (acc_q >> CHUNK) | (WIDTH'(chunk_res[CHUNK-1:0]) << (WIDTH - CHUNK));

    state_d     = state_q;
    cnt_d       = cnt_q;
    a_d         = a_q;
    b_d         = b_q;
    acc_d       = acc_q;
    c_d         = c_q;
    sum_d       = sum_q;
    carry_out_d = carry_out_q;
    overflow_d  = overflow_q;
    zero_d      = zero_q;

    case (state_q)
      IDLE: begin
        if (in_valid) begin
          // Subtraction is a + ~b + ~borrow_in; for subtract, the carry out
          // is therefore the inverted borrow.
          a_d     = a;
          b_d     = sub ? ~b : b;
          c_d     = sub ? ~carry_in : carry_in;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d   = a_q >> CHUNK;
        b_d   = b_q >> CHUNK;
        c_d   = chunk_res[CHUNK];
        acc_d = result;
        cnt_d = cnt_q + CNT_W'(1);
        if (cnt_q == LAST_CNT) begin
          cnt_d       = '0;
          state_d     = DONE;
          sum_d       = result;
          carry_out_d = chunk_res[CHUNK];
          overflow_d  = (a_q[CHUNK-1] == b_q[CHUNK-1]) &&
                        (chunk_res[CHUNK-1] != a_q[CHUNK-1]);
          zero_d      = (result == '0);
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      a_q         <= '0;
      b_q         <= '0;
      acc_q       <= '0;
      c_q         <= 1'b0;
      sum_q       <= '0;
      carry_out_q <= 1'b0;
      overflow_q  <= 1'b0;
      zero_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      a_q         <= a_d;
      b_q         <= b_d;
      acc_q       <= acc_d;
      c_q         <= c_d;
      sum_q       <= sum_d;
      carry_out_q <= carry_out_d;
      overflow_q  <= overflow_d;
      zero_q      <= zero_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign sum       = sum_q;
  assign carry_out = carry_out_q;
  assign overflow  = overflow_q;
  assign zero      = zero_q;

endmodule

// File: tb/tb_rca_seq_adder.sv
// Testbench for rca_seq_adder. Three instances are exercised in parallel:
// 8/4 (directed cases, backpressure, reset mid-run, random), 32/8 and 32/32
// (random). Every accepted operation pushes its expected result, computed with
// plain integer arithmetic, into a per-instance queue. A monitor pops that
// queue when out_valid appears and compares the outputs every cycle that
// out_valid stays high.
module tb_rca_seq_adder;

  typedef struct {
    logic [31:0] sum;
    logic        co;
    logic        ov;
    logic        z;
    longint      acc_cyc;
  } exp_t;

  logic   clk = 1'b0;
  longint cyc = 0;
  int     checks = 0;
  int     errors = 0;

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string name, input longint act, input longint req);
    checks++;
    if (act != req) begin
      errors++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  for (genvar g = 0; g < 3; g++) begin : inst
    localparam int W = (g == 0) ? 8 : 32;
    localparam int C = (g == 0) ? 4 : ((g == 1) ? 8 : 32);
    localparam int N = W / C;

    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         carry_in;
    logic         sub;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] sum;
    logic         carry_out;
    logic         overflow;
    logic         zero;

    exp_t q[$];
    bit   hold_ready = 1'b0;
    bit   done = 1'b0;

    rca_seq_adder #(.WIDTH(W), .CHUNK(C)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .carry_in  (carry_in),
      .sub       (sub),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .sum       (sum),
      .carry_out (carry_out),
      .overflow  (overflow),
      .zero      (zero)
    );

    // Reference model: exact integer arithmetic on the operation itself.
    function automatic exp_t model(input longint av, input longint bv, input bit cv, input bit sv);
      exp_t   e;
      longint half, full, ci, raw, sa, sb, sr;
      half = longint'(1) << (W - 1);
      full = half * 2;
      ci   = cv ? 1 : 0;
      raw  = sv ? (av - bv - ci) : (av + bv + ci);
      e.sum = 32'(raw & (full - 1));
      e.co  = sv ? (av >= bv + ci) : (raw >= full);
      sa    = (av >= half) ? av - full : av;
      sb    = (bv >= half) ? bv - full : bv;
      sr    = sv ? (sa - sb - ci) : (sa + sb + ci);
      e.ov  = (sr >= half) || (sr < -half);
      e.z   = ((raw & (full - 1)) == 0);
      e.acc_cyc = 0;
      return e;
    endfunction

    task automatic applyStimulus(input logic [W-1:0] av, input logic [W-1:0] bv,
                                 input logic cv, input logic sv);
      exp_t e;
      int   waited = 0;
      a = av; b = bv; carry_in = cv; sub = sv; in_valid = 1'b1;
      e = model(longint'(av), longint'(bv), cv, sv);
      while (!in_ready && waited < 400) begin
        @(negedge clk);
        waited++;
      end
      if (!in_ready) begin
        checks++;
        errors++;
        $display("[TB] FAIL u%0d_accept_timeout: in_ready=%0b after %0d cycles, required 1", g, in_ready, waited);
      end else begin
        e.acc_cyc = cyc + 1;
        q.push_back(e);
      end
      @(negedge clk);
      in_valid = 1'b0;
      a = W'($urandom());
      b = W'($urandom());
      carry_in = 1'($urandom());
      sub = 1'($urandom());
    endtask

    task automatic doReset();
      rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; carry_in = 1'b0; sub = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      checkOutput($sformatf("u%0d_rst_in_ready", g), longint'(in_ready), 1);
      checkOutput($sformatf("u%0d_rst_out_valid", g), longint'(out_valid), 0);
      checkOutput($sformatf("u%0d_rst_sum", g), longint'(sum), 0);
      checkOutput($sformatf("u%0d_rst_carry_out", g), longint'(carry_out), 0);
      checkOutput($sformatf("u%0d_rst_overflow", g), longint'(overflow), 0);
      checkOutput($sformatf("u%0d_rst_zero", g), longint'(zero), 0);
      @(negedge clk);
      rst = 1'b0;
    endtask

    task automatic runRandom(input int n);
      for (int i = 0; i < n; i++) begin
        logic [W-1:0] av, bv;
        av = W'($urandom());
        bv = W'($urandom());
        case ($urandom_range(0, 7))
          0: av = '1;
          1: bv = {1'b1, {(W-1){1'b0}}};
          2: av = {1'b0, {(W-1){1'b1}}};
          3: bv = '0;
          default: ;
        endcase
        applyStimulus(av, bv, 1'($urandom()), 1'($urandom()));
        repeat ($urandom_range(0, 2)) @(negedge clk);
      end
    endtask

    task automatic drain();
      hold_ready = 1'b0;
      for (int i = 0; i < 500 && (q.size() != 0 || out_valid); i++) @(negedge clk);
      repeat (2) @(negedge clk);
      checkOutput($sformatf("u%0d_drain_pending", g), longint'(q.size()), 0);
      checkOutput($sformatf("u%0d_drain_out_valid", g), longint'(out_valid), 0);
    endtask

    // Consumer side: random stalls unless a test holds out_ready low.
    initial begin
      out_ready = 1'b0;
      forever begin
        @(negedge clk);
        out_ready = hold_ready ? 1'b0 : ($urandom_range(0, 3) != 0);
      end
    end

    // Monitor: pops on the first cycle of each result and keeps comparing
    // while out_valid stays high, which also covers stability under stalls.
    initial begin : monitor
      exp_t cur;
      bit   have;
      bit   prev_handoff;
      have = 1'b0;
      prev_handoff = 1'b0;
      forever begin
        @(negedge clk);
        #1;
        if (rst) begin
          have = 1'b0;
          prev_handoff = 1'b0;
        end else begin
          if (prev_handoff) begin
            checkOutput($sformatf("u%0d_in_ready_after_handoff", g), longint'(in_ready), 1);
            checkOutput($sformatf("u%0d_out_valid_after_handoff", g), longint'(out_valid), 0);
          end
          prev_handoff = 1'b0;
          if (out_valid) begin
            if (!have) begin
              if (q.size() == 0) begin
                checks++;
                errors++;
                $display("[TB] FAIL u%0d_spurious_result: out_valid=1 with no operation outstanding, required 0", g);
              end else begin
                cur = q.pop_front();
                have = 1'b1;
                checkOutput($sformatf("u%0d_latency", g), cyc - cur.acc_cyc, N);
              end
            end
            if (have) begin
              checkOutput($sformatf("u%0d_sum", g), longint'(sum), longint'(cur.sum));
              checkOutput($sformatf("u%0d_carry_out", g), longint'(carry_out), longint'(cur.co));
              checkOutput($sformatf("u%0d_overflow", g), longint'(overflow), longint'(cur.ov));
              checkOutput($sformatf("u%0d_zero", g), longint'(zero), longint'(cur.z));
              checkOutput($sformatf("u%0d_in_ready_busy", g), longint'(in_ready), 0);
            end
            if (out_ready) begin
              have = 1'b0;
              prev_handoff = 1'b1;
            end
          end
        end
      end
    end

    if (g == 0) begin : g_directed
      initial begin
        doReset();
        applyStimulus(8'hAB, 8'hFF, 1'b0, 1'b0);
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        applyStimulus(8'h7F, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'hFF, 8'h01, 1'b0, 1'b0);
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b1);
        applyStimulus(8'h34, 8'h12, 1'b0, 1'b1);
        drain();

        // Backpressure: first result stalled 5 cycles, second op held waiting.
        hold_ready = 1'b1;
        applyStimulus(8'h12, 8'h34, 1'b0, 1'b0);
        fork
          applyStimulus(8'h34, 8'h12, 1'b0, 1'b1);
          begin
            for (int i = 0; i < 20 && !out_valid; i++) @(negedge clk);
            repeat (5) @(negedge clk);
            hold_ready = 1'b0;
          end
        join
        drain();

        // Reset in the middle of RUN discards the operation.
        applyStimulus(8'h5A, 8'h33, 1'b1, 1'b0);
        rst = 1'b1;
        void'(q.pop_back());
        @(negedge clk);
        rst = 1'b0;
        #1;
        checkOutput("u0_midrst_in_ready", longint'(in_ready), 1);
        checkOutput("u0_midrst_out_valid", longint'(out_valid), 0);
        checkOutput("u0_midrst_sum", longint'(sum), 0);
        checkOutput("u0_midrst_carry_out", longint'(carry_out), 0);
        repeat (N + 3) @(negedge clk);
        checkOutput("u0_midrst_no_result", longint'(out_valid), 0);

        runRandom(300);
        drain();
        $display("[TB] instance 0 stimulus complete");
        done = 1'b1;
      end
    end else begin : g_random
      initial begin
        doReset();
        runRandom(1000);
        drain();
        $display("[TB] instance %0d stimulus complete", g);
        done = 1'b1;
      end
    end
  end

  initial begin
    wait (inst[0].done && inst[1].done && inst[2].done);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #800000;
    checks++;
    errors++;
    $display("[TB] FAIL watchdog: simulation still running at time %0t, required completion", $time);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
